alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
- Iterative multi-cycle execution unit for the MUL and DIV ALU operations.
- Receives the decoded 3-bit aluOp from the ALU wrapper/decode stage together with operands a and b.
- Returns the product or quotient, the remainder, and the ALU flags through a start/done handshake.
- The pipeline stalls on busy; the single-cycle ALU handles all other ops.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  aluOp; MULA=3'b010, DIVA=3'b011, other codes ignored.
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; out, rem, flags and dz are valid from this cycle on.
- out  output  WIDTH  low WIDTH bits of the product, or the quotient.
- rem  output  WIDTH  remainder on DIV; 0 on MUL.
- flags  output  2  flags[1]=Z (out==0), flags[0]=N (out[WIDTH-1]).
- dz  output  1  divide-by-zero indicator for the last DIV; 0 for MUL.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, out=0, rem=0, flags=2'b10, dz=0, counter=0.
- Arithmetic: unsigned for both ops.
  - MUL: shift-add, one bit per cycle; the upper product half is discarded.
  - DIV: restoring division, one quotient bit per cycle; a WIDTH+1-bit partial remainder prevents overflow.
- States: IDLE, RUN, DZ, DONE.
- IDLE:
  - start=1 with op==MULA or op==DIVA and b!=0 → latch a, b and op; clear the accumulator; counter=WIDTH-1; go to RUN.
  - start=1 with op==DIVA and b==0 → go to DZ.
  - start=1 with any other op → ignored; stay IDLE, no done.
- RUN:
  - One iteration per cycle.
  - counter==0 → go to DONE with final results registered.
  - Otherwise decrement the counter.
- DZ (one cycle): register out={WIDTH{1}}, rem=a and dz=1, then go to DONE.
- DONE (one cycle): done=1, busy=1, then go to IDLE.
- Latency, with the start edge as cycle 0:
  - MUL/DIV: done=1 in cycle WIDTH+1 (33 for the default).
  - Divide-by-zero: done=1 in cycle 2.
- Next request: a new start may be accepted in the cycle after DONE, when state is back in IDLE.
- Result hold: out, rem, flags and dz hold their values after done until the next accepted request completes. They are not cleared on accept.
- Flags: computed from the final out at completion, including the divide-by-zero case (Z=0, N=1).
- Operand stability: operands and op are latched at accept; changes to a, b or op while busy have no effect.
- start while busy: ignored and not queued. The requester must hold or re-issue it after busy falls.
- Reset mid-operation: rst=1 in any state forces reset values on the next edge and abandons the operation; no done pulse is produced for it.
- Simultaneous rst and start: rst wins; the request is not accepted.
- MUL edge cases:
  - a=0 or b=0 still takes full latency.
  - Overflow wraps to the low WIDTH bits; no overflow flag.
- DIV edge cases:
  - a<b → out=0, rem=a, Z=1.
  - a==b → out=1, rem=0.

Test Plan:
- Basic MUL: op=MULA, a=7, b=6, start pulse → busy=1 in cycles 1-33; done=1 only in cycle 33; out=42, rem=0, flags=2'b00, dz=0.
- MUL overflow: a=32'hFFFFFFFF, b=2 → out=32'hFFFFFFFE, flags=2'b01; a=32'h00010000, b=32'h00010000 → out=0, flags=2'b10.
- DIV: a=100, b=7 → out=14, rem=2 at cycle 33; then a=5, b=9 → out=0, rem=5, flags=2'b10.
- Divide by zero: op=DIVA, a=32'h1234, b=0 → done in cycle 2; out=32'hFFFFFFFF, rem=32'h1234, dz=1, flags=2'b01. A following MUL 3*3 clears dz and gives out=9.
- Ignored requests:
  - start with op=ADDA (3'b000) → no busy, no done, outputs unchanged.
  - During a running DIV 100/7, pulse start with MUL 2*2 and change a and b → DIV still returns 14/2; no second done.
- Reset mid-op: rst=1 at cycle 10 of MUL 7*6 → next cycle busy=0, out=0, flags=2'b10. A fresh DIV 81/9 then returns out=9, rem=0 after full latency.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit
//   Iterative unsigned MUL / DIV engine behind the single-cycle ALU.
//   MUL is shift-add (LSB first), DIV is restoring, one bit per clock.
//   Results, flags and dz are registered and hold until the next
//   accepted request completes.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start, op     request strobe and aluOp (MULA=3'b010, DIVA=3'b011)
//   a, b          multiplicand/dividend, multiplier/divisor
//   busy          high from the cycle after accept through DONE
//   done          one-cycle completion pulse
//   out, rem      product low half or quotient; remainder (0 on MUL)
//   flags         {Z, N} of out
//   dz            divide-by-zero indicator of the last DIV
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic [1:0]       flags,
  output logic             dz
);
  localparam logic [2:0] MULA = 3'b010;
  localparam logic [2:0] DIVA = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DZ, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;      // MUL: shifted multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] r_b;      // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0] r_acc;    // MUL: product accumulator;  DIV: partial remainder
  logic             r_div;
  logic             r_busy, r_done, r_dz;
  logic [WIDTH-1:0] r_out, r_rem;
  logic [1:0]       r_flags;

  // One MUL step: add the shifted multiplicand when the current multiplier bit is set.
  logic [WIDTH-1:0] w_mul_acc;
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

  // One DIV step: shift the next dividend bit into a WIDTH+1 bit partial
  // remainder. The remainder stays below b, so the difference fits WIDTH bits.
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_q;
  assign w_div_sh  = {r_acc, r_a[WIDTH-1]};
  assign w_div_ge  = w_div_sh[WIDTH] | (w_div_sh[WIDTH-1:0] >= r_b);
  assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_b) : w_div_sh[WIDTH-1:0];
  assign w_div_q   = {r_a[WIDTH-2:0], w_div_ge};

  logic [WIDTH-1:0] w_res;
  assign w_res = r_div ? w_div_q : w_mul_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_div   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_rem   <= '0;
      r_flags <= 2'b10;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (op == MULA || op == DIVA)) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_div  <= (op == DIVA);
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_busy <= 1'b1;
            r_state <= (op == DIVA && b == '0) ? S_DZ : S_RUN;
          end
        end
        S_RUN: begin
          if (r_div) begin
            r_acc <= w_div_rem;
            r_a   <= w_div_q;
          end else begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end
          if (r_cnt == '0) begin
            r_out   <= w_res;
            r_rem   <= r_div ? w_div_rem : '0;
            r_dz    <= 1'b0;
            r_flags <= {w_res == '0, w_res[WIDTH-1]};
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DZ: begin
          // All-ones quotient: Z=0, N=1.
          r_out   <= '1;
          r_rem   <= r_a;
          r_dz    <= 1'b1;
          r_flags <= 2'b01;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign out   = r_out;
  assign rem   = r_rem;
  assign flags = r_flags;
  assign dz    = r_dz;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;
  localparam int W = 32;
  localparam logic [2:0] MULA = 3'b010;
  localparam logic [2:0] DIVA = 3'b011;
  localparam logic [2:0] ADDA = 3'b000;

  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] op;
  logic [W-1:0] a, b;
  logic busy, done, dz;
  logic [W-1:0] out, rem;
  logic [1:0] flags;

  int n_chk = 0;
  int n_err = 0;

  alu_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .rem(rem), .flags(flags), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] e_out, e_rem;
    logic [1:0]   e_flags;
    logic         e_dz;
    int           e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a start pulse sampled by the next posedge (cycle 0).
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
  endtask

  // Wait for done, checking busy throughout and the done cycle number.
  // At cycle 'disturb' a MUL 2*2 start is pulsed and operands are changed.
  task automatic wait_done(input string name, input int lat, input int disturb,
                           output int k_done);
    bit busy_ok = 1'b1;
    k_done = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin k_done = k; break; end
      if (k == disturb) begin op = MULA; a = 2; b = 2; start = 1'b1; end
      if (k == disturb + 1) start = 1'b0;
    end
    chk({name, " latency"}, k_done, lat);
    chk({name, " busy"}, busy_ok, 1'b1);
  endtask

  task automatic check_res(input string name, input vec_t v);
    chk({name, " out"}, out, v.e_out);
    chk({name, " rem"}, rem, v.e_rem);
    chk({name, " flags"}, flags, v.e_flags);
    chk({name, " dz"}, dz, v.e_dz);
    @(negedge clk);
    chk({name, " idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int kd;
    bit seen;
    logic [W-1:0] prev_out;
    vec_t v;

    vecs[0]  = '{MULA, 7, 6, 42, 0, 2'b00, 1'b0, 33};
    vecs[1]  = '{MULA, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 0, 2'b01, 1'b0, 33};
    vecs[2]  = '{MULA, 32'h00010000, 32'h00010000, 0, 0, 2'b10, 1'b0, 33};
    vecs[3]  = '{MULA, 0, 5, 0, 0, 2'b10, 1'b0, 33};
    vecs[4]  = '{DIVA, 100, 7, 14, 2, 2'b00, 1'b0, 33};
    vecs[5]  = '{DIVA, 5, 9, 0, 5, 2'b10, 1'b0, 33};
    vecs[6]  = '{DIVA, 7, 7, 1, 0, 2'b00, 1'b0, 33};
    vecs[7]  = '{DIVA, 32'h1234, 0, 32'hFFFFFFFF, 32'h1234, 2'b01, 1'b1, 2};
    vecs[8]  = '{MULA, 3, 3, 9, 0, 2'b00, 1'b0, 33};
    vecs[9]  = '{DIVA, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 2'b01, 1'b0, 33};
    vecs[10] = '{DIVA, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 2'b00, 1'b0, 33};

    rst = 1'b1; start = 1'b0; op = ADDA; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy/done/dz", {busy, done, dz}, 3'b000);
    chk("reset out", out, 0);
    chk("reset rem", rem, 0);
    chk("reset flags", flags, 2'b10);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      start_op(v.op, v.a, v.b);
      wait_done($sformatf("vec%0d", i), v.e_lat, -1, kd);
      check_res($sformatf("vec%0d", i), v);
    end

    // Unsupported op is ignored.
    prev_out = out;
    start_op(ADDA, 1, 2);
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    chk("adda ignored", seen, 1'b0);
    chk("adda out held", out, prev_out);

    // Start and operand changes during a running DIV have no effect.
    start_op(DIVA, 100, 7);
    wait_done("div disturb", 33, 5, kd);
    v = '{DIVA, 0, 0, 14, 2, 2'b00, 1'b0, 33};
    check_res("div disturb", v);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("no second done", seen, 1'b0);

    // Reset in the middle of a MUL abandons it.
    start_op(MULA, 7, 6);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy/done/dz", {busy, done, dz}, 3'b000);
    chk("midrst out", out, 0);
    chk("midrst flags", flags, 2'b10);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("midrst no done", seen, 1'b0);

    // rst wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = MULA; a = 3; b = 3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    chk("rst beats start", seen, 1'b0);

    start_op(DIVA, 81, 9);
    wait_done("div 81/9", 33, -1, kd);
    v = '{DIVA, 81, 9, 9, 0, 2'b00, 1'b0, 33};
    check_res("div 81/9", v);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
